// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the router packet transmitter:
// field widths, header layout and tx state encodings.
package router_pkt_tx_pkg;

   localparam int ADDR_W = 2;
   localparam int LEN_W  = 6;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_LEN_LSB  = ADDR_W;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_FILL,
      TX_HEADER,
      TX_PAYLOAD,
      TX_PARITY,
      TX_GAP
   } tx_state_e;

   function automatic logic [DATA_W-1:0] mk_header(
      input logic [LEN_W-1:0]  len,
      input logic [ADDR_W-1:0] addr
   );
      logic [DATA_W-1:0] h;
      h = '0;
      h[HDR_LEN_LSB +: LEN_W]   = len;
      h[HDR_ADDR_LSB +: ADDR_W] = addr;
      return h;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: MAX_LEN x 8 RAM, synchronous write, asynchronous read.
// Ports: clock, we/wr_addr/wr_data (write), rd_addr -> rd_data (read).
module router_tx_buf
   import router_pkt_tx_pkg::*;
#(
   parameter int MAX_LEN = 63
) (
   input  logic              clock,
   input  logic              we,
   input  logic [LEN_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [MAX_LEN];

   always_ff @(posedge clock) begin
      if (we && (int'(wr_addr) < MAX_LEN))
         mem[wr_addr] <= wr_data;
   end

   // The look-ahead read one past the last byte may address MAX_LEN.
   assign rd_data = (int'(rd_addr) < MAX_LEN) ? mem[rd_addr] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the router input port.
// Ports: host cmd_*/pay_* handshakes, router busy, pkt_valid/data_out, tx_done/tx_active status.
module router_pkt_tx
   import router_pkt_tx_pkg::*;
#(
   parameter int MAX_LEN    = 63,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_perr,
   output logic              cmd_err,
   input  logic              pay_valid,
   output logic              pay_ready,
   input  logic [DATA_W-1:0] pay_data,
   input  logic              busy,
   output logic              pkt_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              tx_done,
   output logic              tx_active
);

   tx_state_e         state, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [LEN_W-1:0]  len_q, len_n;
   logic              perr_q, perr_n;
   logic [LEN_W-1:0]  wr_ptr, wr_n;
   logic [LEN_W-1:0]  rd_ptr, rd_n;
   logic [DATA_W-1:0] parity, par_n;
   logic [7:0]        gap_cnt, gap_n;

   logic              cmd_ready_n, cmd_err_n, pay_ready_n;
   logic              pkt_valid_n, tx_done_n, tx_active_n;
   logic [DATA_W-1:0] data_n;

   logic              buf_we;
   logic [LEN_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data;

   // Look ahead one byte so data_out is loaded on the accepting edge.
   assign rd_addr = (state == TX_HEADER) ? '0 : rd_ptr + 1'b1;

   router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
      .clock   (clock),
      .we      (buf_we),
      .wr_addr (wr_ptr),
      .wr_data (pay_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= TX_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         perr_q    <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         parity    <= '0;
         gap_cnt   <= '0;
         cmd_ready <= 1'b0;
         cmd_err   <= 1'b0;
         pay_ready <= 1'b0;
         pkt_valid <= 1'b0;
         data_out  <= '0;
         tx_done   <= 1'b0;
         tx_active <= 1'b0;
      end else begin
         state     <= state_n;
         addr_q    <= addr_n;
         len_q     <= len_n;
         perr_q    <= perr_n;
         wr_ptr    <= wr_n;
         rd_ptr    <= rd_n;
         parity    <= par_n;
         gap_cnt   <= gap_n;
         cmd_ready <= cmd_ready_n;
         cmd_err   <= cmd_err_n;
         pay_ready <= pay_ready_n;
         pkt_valid <= pkt_valid_n;
         data_out  <= data_n;
         tx_done   <= tx_done_n;
         tx_active <= tx_active_n;
      end
   end

   always_comb begin
      state_n     = state;
      addr_n      = addr_q;
      len_n       = len_q;
      perr_n      = perr_q;
      wr_n        = wr_ptr;
      rd_n        = rd_ptr;
      par_n       = parity;
      gap_n       = gap_cnt;
      cmd_ready_n = 1'b0;
      cmd_err_n   = 1'b0;
      pay_ready_n = pay_ready;
      pkt_valid_n = pkt_valid;
      data_n      = data_out;
      tx_done_n   = 1'b0;
      tx_active_n = tx_active;
      buf_we      = 1'b0;
      unique case (state)
         TX_IDLE: begin
            cmd_ready_n = 1'b1;
            if (cmd_valid && cmd_ready) begin
               if (cmd_addr == ADDR_INVALID || cmd_len == '0) begin
                  cmd_err_n = 1'b1;
               end else begin
                  addr_n      = cmd_addr;
                  len_n       = cmd_len;
                  perr_n      = cmd_perr;
                  wr_n        = '0;
                  cmd_ready_n = 1'b0;
                  pay_ready_n = 1'b1;
                  tx_active_n = 1'b1;
                  state_n     = TX_FILL;
               end
            end
         end
         TX_FILL: begin
            if (pay_valid && pay_ready) begin
               buf_we = 1'b1;
               wr_n   = wr_ptr + 1'b1;
               if (wr_ptr == len_q - 1'b1) begin
                  pay_ready_n = 1'b0;
                  pkt_valid_n = 1'b1;
                  data_n      = mk_header(len_q, addr_q);
                  state_n     = TX_HEADER;
               end
            end
         end
         TX_HEADER: begin
            if (!busy) begin
               par_n   = data_out;
               rd_n    = '0;
               data_n  = rd_data;
               state_n = TX_PAYLOAD;
            end
         end
         TX_PAYLOAD: begin
            if (!busy) begin
               par_n = parity ^ data_out;
               if (rd_ptr == len_q - 1'b1) begin
                  pkt_valid_n = 1'b0;
                  data_n      = parity ^ data_out
                              ^ {{(DATA_W-1){1'b0}}, perr_q};
                  state_n     = TX_PARITY;
               end else begin
                  rd_n   = rd_ptr + 1'b1;
                  data_n = rd_data;
               end
            end
         end
         TX_PARITY: begin
            if (!busy) begin
               tx_done_n = 1'b1;
               data_n    = '0;
               gap_n     = '0;
               state_n   = TX_GAP;
            end
         end
         TX_GAP: begin
            if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
               tx_active_n = 1'b0;
               cmd_ready_n = 1'b1;
               state_n     = TX_IDLE;
            end else begin
               gap_n = gap_cnt + 8'd1;
            end
         end
         default: state_n = TX_IDLE;
      endcase
   end

endmodule
